// File: rtl/multdiv_unit.sv
// multdiv_unit: multi-cycle signed 32-bit multiply / divide for the execute stage.
// Multiply uses radix-2 Booth, divide uses restoring division on magnitudes.
// Every operation takes exactly ITER edges after the start edge, and a one-cycle
// completion pulse accompanies the registered result and exception flag.
module multdiv_unit #(
    parameter int ITER = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [4:0] LAST = 5'(ITER - 1);

    // Booth register is {acc[32:0], Q[31:0], q-1}. The accumulator carries one
    // guard bit beyond 32 so that subtracting a multiplicand of -2^31 never wraps.
    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          is_div_q, is_div_d;
    logic [65:0]   booth_q, booth_d;
    logic [32:0]   mcand_q, mcand_d;
    logic [32:0]   rem_q, rem_d;
    logic [31:0]   quo_q, quo_d;
    logic [31:0]   dvsr_q, dvsr_d;
    logic          neg_q, neg_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   result_q, result_d;
    logic          exc_q, exc_d;
    logic          rdy_q, rdy_d;

    logic          start;
    logic [65:0]   booth_nx;
    logic [64:0]   div_nx;

    // One Booth step: add/subtract per {Q0, q-1}, then arithmetic shift right.
    function automatic logic [65:0] booth_step(input logic [65:0] r, input logic [32:0] m);
        logic [32:0]        acc;
        logic signed [65:0] t;
        acc = r[65:33];
        case (r[1:0])
            2'b01:   acc = acc + m;
            2'b10:   acc = acc - m;
            default: acc = r[65:33];
        endcase
        t = {acc, r[32:0]};
        return 66'(t >>> 1);
    endfunction

    // One restoring-division step; returns {remainder[32:0], quotient[31:0]}.
    function automatic logic [64:0] div_step(input logic [32:0] rem, input logic [31:0] quo,
                                             input logic [31:0] dvsr);
        logic [33:0] shifted;
        logic [33:0] trial;
        shifted = {rem, quo[31]};
        trial   = shifted - {2'b00, dvsr};
        if (trial[33]) begin
            return {shifted[32:0], quo[30:0], 1'b0};
        end
        return {trial[32:0], quo[30:0], 1'b1};
    endfunction

    // Unsigned magnitude of a two's-complement value (0x80000000 maps to itself).
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    // Re-apply the quotient sign after magnitude division.
    function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // Product does not fit in signed 32 bits unless bits [63:31] are all equal.
    function automatic logic mul_overflow(input logic [63:0] p);
        return !((&p[63:31]) || !(|p[63:31]));
    endfunction

    assign start    = ctrl_MULT | ctrl_DIV;
    assign booth_nx = booth_step(booth_q, mcand_q);
    assign div_nx   = div_step(rem_q, quo_q, dvsr_q);

    // Next-state, datapath iteration and completion logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        booth_d  = booth_q;
        mcand_d  = mcand_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (start) begin
            // A new start always wins: any in-flight operation is dropped silently.
            state_d  = RUN;
            cnt_d    = 5'd0;
            is_div_d = !ctrl_MULT;
            booth_d  = {33'd0, data_operandB, 1'b0};
            mcand_d  = {data_operandA[31], data_operandA};
            rem_d    = 33'd0;
            quo_d    = mag32(data_operandA);
            dvsr_d   = mag32(data_operandB);
            neg_d    = data_operandA[31] ^ data_operandB[31];
            dz_d     = (data_operandB == 32'd0);
            ovf_d    = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        end else begin
            case (state_q)
                RUN: begin
                    cnt_d = cnt_q + 5'd1;
                    if (is_div_q) begin
                        {rem_d, quo_d} = div_nx;
                    end else begin
                        booth_d = booth_nx;
                    end
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        rdy_d   = 1'b1;
                        if (is_div_q) begin
                            if (dz_q) begin
                                result_d = 32'd0;
                                exc_d    = 1'b1;
                            end else if (ovf_q) begin
                                result_d = 32'h8000_0000;
                                exc_d    = 1'b1;
                            end else begin
                                result_d = apply_sign(div_nx[31:0], neg_q);
                                exc_d    = 1'b0;
                            end
                        end else begin
                            result_d = booth_nx[32:1];
                            exc_d    = mul_overflow(booth_nx[64:1]);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers; async reset clears everything.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            is_div_q <= 1'b0;
            booth_q  <= 66'd0;
            mcand_q  <= 33'd0;
            rem_q    <= 33'd0;
            quo_q    <= 32'd0;
            dvsr_q   <= 32'd0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            booth_q  <= booth_d;
            mcand_q  <= mcand_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule
